// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: states, opcodes,
// ALUOp codes and datapath select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        I_EXEC   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        JR       = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALUOP_ADD   = 4'b0100;
    localparam logic [3:0] ALUOP_RTYPE = 4'b0111;
    localparam logic [3:0] ALUOP_ANDI  = 4'b0101;
    localparam logic [3:0] ALUOP_ORI   = 4'b0110;
    localparam logic [3:0] ALUOP_LUI   = 4'b0011;
    localparam logic [3:0] ALUOP_BEQ   = 4'b1000;
    localparam logic [3:0] ALUOP_BNE   = 4'b1001;
    localparam logic [3:0] ALUOP_LW    = 4'b1010;
    localparam logic [3:0] ALUOP_SW    = 4'b1011;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       PCWrite;
    logic       ExtZero;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [3:0] ALUOp;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, PCWrite,
               ExtZero, ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp,
               instr_done, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, PCWrite,
               ExtZero, ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp,
               instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_control_aluop_encoder.sv
// Maps an opcode to the ALUOp code for the ALU control decoder. is_mem
// selects the lw/sw address-calculation codes.
module aluop_encoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       is_mem,
    output logic [3:0] aluop
);

    // Opcode to ALUOp lookup; unknown opcodes fall back to a plain add.
    always_comb begin
        aluop = ALUOP_ADD;
        if (is_mem) begin
            aluop = (opcode == OP_SW) ? ALUOP_SW : ALUOP_LW;
        end else begin
            case (opcode)
                OP_ADDI: aluop = ALUOP_ADD;
                OP_ANDI: aluop = ALUOP_ANDI;
                OP_ORI:  aluop = ALUOP_ORI;
                OP_LUI:  aluop = ALUOP_LUI;
                OP_BEQ:  aluop = ALUOP_BEQ;
                OP_BNE:  aluop = ALUOP_BNE;
                default: aluop = ALUOP_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: steps each instruction through
// fetch/decode/execute/memory/write-back and drives all datapath selects.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t     state_reg, state_next;
    logic       rd_sel_reg, rd_sel_next;   // 1: ALU_WB writes rd (R-type), 0: rt
    logic [3:0] enc_aluop;

    logic       iord, mem_read, mem_write, ir_write, reg_write;
    logic       alu_src_a, pc_write, ext_zero, done, illegal_raw;
    logic [1:0] alu_src_b, pc_source, reg_dst, mem_to_reg;
    logic [3:0] alu_op;

    aluop_encoder u_aluop_encoder (
        .opcode (bus.opcode),
        .is_mem (state_reg == MEM_ADDR),
        .aluop  (enc_aluop)
    );

    // State and write-back destination flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= FETCH;
            rd_sel_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_sel_reg <= rd_sel_next;
        end
    end

    // Next-state and Moore output decode; only PCWrite/IRWrite/instr_done
    // also look at mem_ready or zero.
    always_comb begin
        state_next  = state_reg;
        rd_sel_next = rd_sel_reg;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        pc_write    = 1'b0;
        ext_zero    = 1'b0;
        done        = 1'b0;
        illegal_raw = 1'b0;
        alu_src_b   = SRCB_B;
        pc_source   = PCSRC_ALU;
        reg_dst     = REGDST_RT;
        mem_to_reg  = M2R_ALUOUT;
        alu_op      = 4'b0000;
        case (state_reg)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALUOP_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = MEM_ADDR;
                    OP_RTYPE: begin
                        if (bus.funct == FN_JR) begin
                            state_next = JR;
                        end else begin
                            state_next  = R_EXEC;
                            rd_sel_next = 1'b1;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                        state_next  = I_EXEC;
                        rd_sel_next = 1'b0;
                    end
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_J, OP_JAL:   state_next = JUMP;
                    default: begin
                        state_next  = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = enc_aluop;
                state_next = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = M2R_MDR;
                done       = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) begin
                    done       = 1'b1;
                    state_next = FETCH;
                end
            end
            R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_B;
                alu_op     = ALUOP_RTYPE;
                state_next = ALU_WB;
            end
            I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = enc_aluop;
                ext_zero   = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
                state_next = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_ALUOUT;
                reg_dst    = rd_sel_reg ? REGDST_RD : REGDST_RT;
                done       = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_B;
                alu_op     = enc_aluop;
                pc_source  = PCSRC_ALUOUT;
                pc_write   = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
                done       = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
                if (bus.opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RA;
                    mem_to_reg = M2R_PC;
                end
                done       = 1'b1;
                state_next = FETCH;
            end
            JR: begin
                pc_source  = PCSRC_REGA;
                pc_write   = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Enables and pulses are suppressed while reset is held low so an
    // abandoned instruction cannot write anything.
    assign bus.MemWrite   = mem_write & reset;
    assign bus.RegWrite   = reg_write & reset;
    assign bus.IRWrite    = ir_write & reset;
    assign bus.PCWrite    = pc_write & reset;
    assign bus.instr_done = done & reset;
    assign bus.illegal    = illegal_raw & reset;

    assign bus.IorD     = iord;
    assign bus.MemRead  = mem_read;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ExtZero  = ext_zero;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.PCSource = pc_source;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.ALUOp    = alu_op;
    assign bus.state    = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, lw with stalls, sw, add,
// ori, beq/bne, jal, jr and an illegal opcode.
module tb_multicycle_control;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rw_cnt   = 0;
    int   done_cnt = 0;
    int   c0, rw0, d0;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles and committed register writes / completed instructions.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.RegWrite)   rw_cnt   <= rw_cnt + 1;
        if (bus.instr_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc(input logic mr, input logic z);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.zero      = z;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;

        // Power-on reset; mem_ready=1 in FETCH must not leak enables.
        @(negedge clk); @(negedge clk);
        bus.mem_ready = 1'b1; #1;
        chk("por_state", bus.state, 4'd0);
        chk("por_irwrite", bus.IRWrite, 1'b0);
        chk("por_pcwrite", bus.PCWrite, 1'b0);
        chk("por_done", bus.instr_done, 1'b0);
        $display("txn: power-on reset state=%0d", bus.state);

        // Start lw, then reset while stuck in MEM_RD.
        @(negedge clk); reset = 1'b1; bus.opcode = 6'b100011; #1;
        chk("f0_irwrite", bus.IRWrite, 1'b1);
        chk("f0_pcwrite", bus.PCWrite, 1'b1);
        next_cyc(1'b1, 1'b0);
        chk("lw0_decode", bus.state, 4'd1);
        chk("lw0_decode_srcb", bus.ALUSrcB, 2'b11);
        next_cyc(1'b1, 1'b0);
        chk("lw0_memaddr", bus.state, 4'd2);
        chk("lw0_memaddr_aluop", bus.ALUOp, 4'b1010);
        next_cyc(1'b0, 1'b0);
        chk("lw0_memrd", bus.state, 4'd3);
        @(negedge clk); reset = 1'b0; bus.mem_ready = 1'b1; #1;
        chk("rst_memrd_state", bus.state, 4'd3);
        chk("rst_memrd_regwrite", bus.RegWrite, 1'b0);
        chk("rst_memrd_done", bus.instr_done, 1'b0);
        chk("rst_memrd_pcwrite", bus.PCWrite, 1'b0);
        @(negedge clk); #1;
        chk("rst_fetch_state", bus.state, 4'd0);
        chk("rst_fetch_irwrite", bus.IRWrite, 1'b0);
        chk("rst_fetch_pcwrite", bus.PCWrite, 1'b0);
        $display("txn: reset mid-MEM_RD -> state=%0d", bus.state);

        // lw with two stall cycles in MEM_RD: 7 cycles.
        @(negedge clk); reset = 1'b1; bus.mem_ready = 1'b1; #1;
        chk("lw_fetch_iord", bus.IorD, 1'b0);
        chk("lw_fetch_memread", bus.MemRead, 1'b1);
        chk("lw_fetch_irwrite", bus.IRWrite, 1'b1);
        c0 = cyc; rw0 = rw_cnt; d0 = done_cnt;
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("lw_memaddr", bus.state, 4'd2);
        next_cyc(1'b0, 1'b0);
        chk("lw_memrd_iord", bus.IorD, 1'b1);
        next_cyc(1'b0, 1'b0);
        chk("lw_memrd_hold", bus.state, 4'd3);
        next_cyc(1'b1, 1'b0);
        chk("lw_memrd_exit", bus.state, 4'd3);
        next_cyc(1'b1, 1'b0);
        chk("lw_memwb_state", bus.state, 4'd4);
        chk("lw_memwb_regwrite", bus.RegWrite, 1'b1);
        chk("lw_memwb_memtoreg", bus.MemtoReg, 2'b01);
        chk("lw_memwb_regdst", bus.RegDst, 2'b00);
        chk("lw_memwb_done", bus.instr_done, 1'b1);
        chk("lw_cycles", cyc - c0, 6);
        next_cyc(1'b1, 1'b0);
        chk("lw_back_fetch", bus.state, 4'd0);
        chk("lw_rw_count", rw_cnt - rw0, 1);
        chk("lw_done_count", done_cnt - d0, 1);
        $display("txn: lw stalled 2 cycles, took %0d cycles", cyc - c0);

        // sw: MEM_WR with immediate ready.
        bus.opcode = 6'b101011;
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("sw_memaddr_aluop", bus.ALUOp, 4'b1011);
        next_cyc(1'b1, 1'b0);
        chk("sw_memwr_state", bus.state, 4'd5);
        chk("sw_memwr_memwrite", bus.MemWrite, 1'b1);
        chk("sw_memwr_done", bus.instr_done, 1'b1);
        next_cyc(1'b1, 1'b0);
        chk("sw_back_fetch", bus.state, 4'd0);
        $display("txn: sw");

        // add (R-type).
        bus.opcode = 6'b000000; bus.funct = 6'b100000;
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("add_rexec_state", bus.state, 4'd6);
        chk("add_rexec_aluop", bus.ALUOp, 4'b0111);
        next_cyc(1'b1, 1'b0);
        chk("add_wb_regwrite", bus.RegWrite, 1'b1);
        chk("add_wb_regdst", bus.RegDst, 2'b01);
        chk("add_wb_memtoreg", bus.MemtoReg, 2'b00);
        next_cyc(1'b1, 1'b0);
        $display("txn: add");

        // ori: zero-extended immediate, writes rt.
        bus.opcode = 6'b001101;
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("ori_iexec_aluop", bus.ALUOp, 4'b0110);
        chk("ori_iexec_extzero", bus.ExtZero, 1'b1);
        next_cyc(1'b1, 1'b0);
        chk("ori_wb_regwrite", bus.RegWrite, 1'b1);
        chk("ori_wb_regdst", bus.RegDst, 2'b00);
        next_cyc(1'b1, 1'b0);
        $display("txn: ori");

        // beq taken, beq not taken, bne taken.
        bus.opcode = 6'b000100;
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b1);
        chk("beq1_state", bus.state, 4'd9);
        chk("beq1_pcwrite", bus.PCWrite, 1'b1);
        chk("beq1_pcsource", bus.PCSource, 2'b01);
        chk("beq1_aluop", bus.ALUOp, 4'b1000);
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("beq0_pcwrite", bus.PCWrite, 1'b0);
        chk("beq0_pcsource", bus.PCSource, 2'b01);
        next_cyc(1'b1, 1'b0);
        bus.opcode = 6'b000101;
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("bne0_pcwrite", bus.PCWrite, 1'b1);
        chk("bne0_pcsource", bus.PCSource, 2'b01);
        chk("bne0_aluop", bus.ALUOp, 4'b1001);
        next_cyc(1'b1, 1'b0);
        $display("txn: beq z=1, beq z=0, bne z=0");

        // jal.
        bus.opcode = 6'b000011;
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("jal_state", bus.state, 4'd10);
        chk("jal_pcwrite", bus.PCWrite, 1'b1);
        chk("jal_pcsource", bus.PCSource, 2'b10);
        chk("jal_regwrite", bus.RegWrite, 1'b1);
        chk("jal_regdst", bus.RegDst, 2'b10);
        chk("jal_memtoreg", bus.MemtoReg, 2'b10);
        next_cyc(1'b1, 1'b0);
        $display("txn: jal");

        // jr.
        bus.opcode = 6'b000000; bus.funct = 6'b001000;
        next_cyc(1'b1, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("jr_state", bus.state, 4'd11);
        chk("jr_pcsource", bus.PCSource, 2'b11);
        chk("jr_pcwrite", bus.PCWrite, 1'b1);
        next_cyc(1'b1, 1'b0);
        $display("txn: jr");

        // Illegal opcode: pulse in DECODE, back to FETCH without writes.
        bus.opcode = 6'b111111;
        rw0 = rw_cnt; d0 = done_cnt;
        next_cyc(1'b1, 1'b0);
        chk("ill_decode_state", bus.state, 4'd1);
        chk("ill_pulse", bus.illegal, 1'b1);
        chk("ill_regwrite", bus.RegWrite, 1'b0);
        chk("ill_pcwrite", bus.PCWrite, 1'b0);
        next_cyc(1'b1, 1'b0);
        chk("ill_back_fetch", bus.state, 4'd0);
        chk("ill_pulse_end", bus.illegal, 1'b0);
        chk("ill_no_writes", rw_cnt - rw0, 0);
        chk("ill_no_done", done_cnt - d0, 0);
        $display("txn: illegal opcode 111111");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
